// File: rtl/bcla9_stream_adder.sv
// bcla9_stream_adder: two-stage valid/ready wrapper around a 9+9-bit
// block carry look-ahead adder, with a saturating carry-out counter.
module bcla9_stream_adder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_x,
  input  logic [8:0]       in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_sum,
  output logic [CNT_W-1:0] carry_cnt,
  input  logic             cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       s1_valid;
  logic [8:0] s1_x;
  logic [8:0] s1_y;
  logic       s2_valid;
  logic       s2_free;
  logic       in_xfer;
  logic       adv;
  logic       out_xfer;

  logic [8:0] p;
  logic [8:0] g;
  logic [2:0] bg;
  logic [2:0] bp;
  logic [3:0] bc;
  logic [9:0] c;
  logic [9:0] sum_c;

  assign s2_free   = !s2_valid | out_ready;
  assign in_ready  = !s1_valid | s2_free;
  assign in_xfer   = in_valid & in_ready;
  assign adv       = s1_valid & s2_free;
  assign out_xfer  = s2_valid & out_ready;
  assign out_valid = s2_valid;

  // 3x3-bit block carry look-ahead adder, carry-in tied low
  always_comb begin
    p  = s1_x ^ s1_y;
    g  = s1_x & s1_y;
    bg = '0;
    bp = '0;
    for (int b = 0; b < 3; b++) begin
      bg[b] = g[3*b+2]
            | (p[3*b+2] & g[3*b+1])
            | (p[3*b+2] & p[3*b+1] & g[3*b]);
      bp[b] = p[3*b+2] & p[3*b+1] & p[3*b];
    end
    bc[0] = 1'b0;
    bc[1] = bg[0];
    bc[2] = bg[1] | (bp[1] & bg[0]);
    bc[3] = bg[2]
          | (bp[2] & bg[1])
          | (bp[2] & bp[1] & bg[0]);
    c = '0;
    for (int b = 0; b < 3; b++) begin
      c[3*b]   = bc[b];
      c[3*b+1] = g[3*b] | (p[3*b] & bc[b]);
      c[3*b+2] = g[3*b+1]
               | (p[3*b+1] & g[3*b])
               | (p[3*b+1] & p[3*b] & bc[b]);
    end
    c[9]  = bc[3];
    sum_c = {c[9], p ^ c[8:0]};
  end

  // stage 1: operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_x     <= in_x;
      s1_y     <= in_y;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  // stage 2: sum register, value held after drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sum  <= '0;
    end else if (adv) begin
      s2_valid <= 1'b1;
      out_sum  <= sum_c;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // saturating count of delivered results with carry-out set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt <= '0;
    end else if (cnt_clr) begin
      carry_cnt <= '0;
    end else if (out_xfer && out_sum[9] && carry_cnt != CNT_MAX) begin
      carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bcla9_stream_adder.sv
// tb_bcla9_stream_adder: random and directed stimulus against a
// queue-based model of the two-entry adder stream.
module tb_bcla9_stream_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_x = '0;
  logic [8:0]  in_y = '0;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        in_ready, in_ready2;
  logic        out_valid, out_valid2;
  logic [9:0]  out_sum, out_sum2;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;

  int n_tests = 0;
  int n_fail = 0;

  logic [9:0] q[$];
  int  m16, m2;
  bit  hold;
  logic [9:0] hold_sum;

  always #5 clk = ~clk;

  bcla9_stream_adder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .carry_cnt(cnt16),
    .cnt_clr(cnt_clr)
  );

  bcla9_stream_adder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(out_sum2), .carry_cnt(cnt2),
    .cnt_clr(cnt_clr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model: predicts transfers at the coming edge from the negedge view
  always @(negedge clk) begin
    logic [9:0] e;
    bit carry;
    if (!rst_n) begin
      q.delete();
      m16 = 0;
      m2 = 0;
      hold = 0;
    end else begin
      carry = 0;
      chk("cnt16", 32'(cnt16), 32'(m16));
      chk("cnt2", 32'(cnt2), 32'(m2));
      chk("ready2", 32'(in_ready2), 32'(in_ready));
      chk("valid2", 32'(out_valid2), 32'(out_valid));
      if (hold) begin
        chk("hold_v", 32'(out_valid), 32'd1);
        chk("hold_sum", 32'(out_sum), 32'(hold_sum));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sum", 32'(out_sum), 32'(e));
          chk("sum2", 32'(out_sum2), 32'(e));
          carry = (e >= 10'd512);
        end
      end
      hold = out_valid && !out_ready;
      hold_sum = out_sum;
      if (cnt_clr) begin
        m16 = 0;
        m2 = 0;
      end else if (carry) begin
        if (m16 < 65535) m16++;
        if (m2 < 3) m2++;
      end
      if (in_valid && in_ready)
        q.push_back(10'(in_x) + 10'(in_y));
    end
  end

  initial begin
    int cexp;
    int lst2 [5] = '{1, 2, 3, 3, 3};
    logic [8:0] bx [3] = '{9'h000, 9'h1FF, 9'h100};
    logic [8:0] by [3] = '{9'h000, 9'h1FF, 9'h0FF};

    // reset state
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_cnt", 32'(cnt16), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    #3 rst_n = 1'b1;
    step();

    // single transfer
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_x = 9'h1FF;
    in_y = 9'h001;
    step();
    in_valid = 1'b0;
    chk("lat_v0", 32'(out_valid), 32'd0);
    step();
    chk("lat_v1", 32'(out_valid), 32'd1);
    chk("one_sum", 32'(out_sum), 32'h200);
    chk("one_cnt0", 32'(cnt16), 32'd0);
    step();
    chk("one_cnt1", 32'(cnt16), 32'd1);
    chk("one_drain", 32'(out_valid), 32'd0);

    // streaming
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    cexp = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_x = 9'($urandom);
      in_y = 9'($urandom);
      if (32'(in_x) + 32'(in_y) >= 512) cexp++;
      chk("str_ready", 32'(in_ready), 32'd1);
      step();
      if (i >= 1) chk("str_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("str_cnt", 32'(cnt16), 32'(cexp));

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_x = 9'd3;
    in_y = 9'd4;
    step();
    in_x = 9'd5;
    in_y = 9'd6;
    chk("bp_rdy2", 32'(in_ready), 32'd1);
    step();
    in_x = 9'd7;
    in_y = 9'd8;
    chk("bp_rdy3", 32'(in_ready), 32'd0);
    step();
    chk("bp_stall", 32'(in_ready), 32'd0);
    chk("bp_sum", 32'(out_sum), 32'd7);
    step();
    chk("bp_sum_b", 32'(out_sum), 32'd7);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_r11", 32'(out_sum), 32'd11);
    step();
    chk("bp_r15", 32'(out_sum), 32'd15);
    chk("bp_v15", 32'(out_valid), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_keep", 32'(out_sum), 32'd15);

    // boundaries
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_x = bx[i];
      in_y = by[i];
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("bnd_cnt", 32'(cnt16), 32'd1);
    chk("bnd_last", 32'(out_sum), 32'h1FF);

    // CNT_W=2 saturation
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_x = 9'h1FF;
      in_y = 9'h0FF;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("sat2", 32'(cnt2), 32'(lst2[k]));
      chk("sat16", 32'(cnt16), 32'(k + 1));
    end

    // clear beats a same-cycle increment
    in_valid = 1'b1;
    in_x = 9'h180;
    in_y = 9'h180;
    step();
    in_valid = 1'b0;
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_pri16", 32'(cnt16), 32'd0);
    chk("clr_pri2", 32'(cnt2), 32'd0);

    // reset with both stages full
    in_valid = 1'b1;
    in_x = 9'h1F0;
    in_y = 9'h1F0;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    chk("pre_cnt", 32'(cnt16), 32'd1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_x = 9'd100;
    in_y = 9'd200;
    step();
    in_x = 9'd50;
    in_y = 9'd60;
    step();
    in_valid = 1'b0;
    chk("full_rdy", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_sum", 32'(out_sum), 32'd0);
    chk("ar_cnt", 32'(cnt16), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    step();
    #3 rst_n = 1'b1;
    step();
    chk("post_idle", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_x = 9'd2;
    in_y = 9'd3;
    step();
    in_valid = 1'b0;
    step();
    chk("post_v", 32'(out_valid), 32'd1);
    chk("post_sum", 32'(out_sum), 32'd5);
    repeat (3) step();
    chk("q_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
